// File: rtl/custom_subtractor37_3_if.sv
// Operand/result handshake bundle for custom_subtractor37_3.
// The zero port exists only when CUSTOM_SUB_ZERO_FLAG_EN is defined.
interface custom_subtractor37_3_if #(
   parameter int unsigned WIDTH_A = 37,
   parameter int unsigned WIDTH_B = 34
);
   logic               in_valid;
   logic               in_ready;
   logic [WIDTH_A-1:0] A;
   logic [WIDTH_B-1:0] B;
   logic               out_valid;
   logic               out_ready;
   logic [WIDTH_A:0]   Diff;
`ifdef CUSTOM_SUB_ZERO_FLAG_EN
   logic               zero;

   modport master (
      output in_valid, A, B, out_ready,
      input  in_ready, out_valid, Diff, zero
   );
   modport slave (
      input  in_valid, A, B, out_ready,
      output in_ready, out_valid, Diff, zero
   );
`else
   modport master (
      output in_valid, A, B, out_ready,
      input  in_ready, out_valid, Diff
   );
   modport slave (
      input  in_valid, A, B, out_ready,
      output in_ready, out_valid, Diff
   );
`endif
endinterface

// File: rtl/custom_subtractor37_3.sv
// Chunked ripple-borrow subtractor: Diff = A - zext(B), CHUNK bits per cycle.
// Optional zero flag is built when CUSTOM_SUB_ZERO_FLAG_EN is defined.
module custom_subtractor37_3 #(
   parameter int unsigned WIDTH_A = 37,
   parameter int unsigned WIDTH_B = 34,
   parameter int unsigned CHUNK   = 8
) (
   input logic                    clk,
   input logic                    rst_n,
   custom_subtractor37_3_if.slave bus
);
   localparam int unsigned NCHUNK = (WIDTH_A + CHUNK - 1) / CHUNK;
   localparam int unsigned IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e             state_q;
   logic [WIDTH_A-1:0] a_q;
   logic [WIDTH_A-1:0] b_q;
   logic [WIDTH_A-1:0] diff_q;
   logic               sign_q;
   logic               borrow_q;
   logic               out_valid_q;
   logic [IDX_W-1:0]   idx_q;

   int unsigned        shift;
   logic [CHUNK-1:0]   a_chunk;
   logic [CHUNK-1:0]   b_chunk;
   logic [CHUNK:0]     sub;
   logic [WIDTH_A-1:0] chunk_mask;
   logic [WIDTH_A-1:0] chunk_val;
   logic [WIDTH_A-1:0] diff_next;

   // Bits of the last chunk above WIDTH_A shift out of the vector and are dropped.
   always_comb begin
      shift      = 32'(idx_q) * CHUNK;
      a_chunk    = CHUNK'(a_q >> shift);
      b_chunk    = CHUNK'(b_q >> shift);
      sub        = {1'b0, a_chunk} - {1'b0, b_chunk} - {{CHUNK{1'b0}}, borrow_q};
      chunk_mask = WIDTH_A'({CHUNK{1'b1}}) << shift;
      chunk_val  = WIDTH_A'(sub[CHUNK-1:0]) << shift;
      diff_next  = (diff_q & ~chunk_mask) | chunk_val;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         a_q         <= '0;
         b_q         <= '0;
         diff_q      <= '0;
         sign_q      <= 1'b0;
         borrow_q    <= 1'b0;
         out_valid_q <= 1'b0;
         idx_q       <= '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (bus.in_valid) begin
                  a_q      <= bus.A;
                  b_q      <= WIDTH_A'(bus.B);
                  idx_q    <= '0;
                  borrow_q <= 1'b0;
                  state_q  <= StRun;
               end
            end
            StRun: begin
               diff_q   <= diff_next;
               borrow_q <= sub[CHUNK];
               idx_q    <= idx_q + IDX_W'(1);
               if (idx_q == LAST_IDX) begin
                  sign_q      <= sub[CHUNK];
                  out_valid_q <= 1'b1;
                  state_q     <= StDone;
               end
            end
            StDone: begin
               if (bus.out_ready) begin
                  out_valid_q <= 1'b0;
                  state_q     <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign bus.in_ready  = (state_q == StIdle);
   assign bus.out_valid = out_valid_q;
   assign bus.Diff      = {sign_q, diff_q};

`ifdef CUSTOM_SUB_ZERO_FLAG_EN
   logic nz_q;
   logic zero_q;

   // Sticky OR of every written chunk; the final borrow also makes Diff nonzero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         nz_q   <= 1'b0;
         zero_q <= 1'b0;
      end else if (state_q == StIdle && bus.in_valid) begin
         nz_q   <= 1'b0;
         zero_q <= 1'b0;
      end else if (state_q == StRun) begin
         nz_q <= nz_q | (chunk_val != '0);
         if (idx_q == LAST_IDX) begin
            zero_q <= !(nz_q || (chunk_val != '0) || sub[CHUNK]);
         end
      end
   end

   assign bus.zero = zero_q;
`endif

endmodule
